xillybus_lite_regfile: RTL and testbench



---
 rtl/xillybus_regs_pkg.sv | 15 +
 rtl/xillybus_irq_ctrl.sv | 30 +++
 rtl/xillybus_lite_regfile.sv | 119 +++++++++++
 tb/tb_xillybus_lite_regfile.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xillybus_regs_pkg.sv
// xillybus_regs_pkg: register word indices, AXI response codes and byte-lane merge for xillybus_lite_regfile
package xillybus_regs_pkg;
  localparam logic [9:0] REG_CTRL      = 10'd0;
  localparam logic [9:0] REG_STATUS    = 10'd1;
  localparam logic [9:0] REG_IRQ_PEND  = 10'd2;
  localparam logic [9:0] REG_IRQ_EN    = 10'd3;
  localparam logic [9:0] REG_USER_BASE = 10'd4;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/xillybus_irq_ctrl.sv
// xillybus_irq_ctrl: 8-source rising-edge interrupt latch with write-1-to-clear pending, enable mask and registered request
//   clk/rst_n: clock, async active-low reset
//   irq_in: sources; en_we/en_wdata: enable-register write; clr: W1C mask for this cycle
//   pend/en: register contents for readback; host_interrupt: registered |(pend & en)
module xillybus_irq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic       en_we,
  input  logic [7:0] en_wdata,
  input  logic [7:0] clr,
  output logic [7:0] pend,
  output logic [7:0] en,
  output logic       host_interrupt
);
  logic [7:0] irq_d;
  // a new edge outranks a clear of the same bit so no event is lost
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      irq_d          <= '0;
      pend           <= '0;
      en             <= '0;
      host_interrupt <= 1'b0;
    end else begin
      irq_d          <= irq_in;
      pend           <= (pend & ~clr) | (irq_in & ~irq_d);
      en             <= en_we ? en_wdata : en;
      host_interrupt <= |(pend & en);
    end
endmodule

// File: rtl/xillybus_lite_regfile.sv
// xillybus_lite_regfile: AXI4-Lite slave with CTRL, STATUS, IRQ_PEND/IRQ_EN and C_NUM_USER user registers
//   S_AXI_ACLK/S_AXI_ARESETN: clock, async active-low reset
//   S_AXI_AW*/W*/B*/AR*/R*: AXI4-Lite slave channels, addr[11:2] decoded
//   ctrl_out: CTRL; status_in: STATUS readback; irq_in: edge-triggered sources
//   user_regs: USER[N] at [32N+31:32N]; host_interrupt: registered interrupt request
module xillybus_lite_regfile
  import xillybus_regs_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_USER         = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     ctrl_out,
  input  logic [31:0]                     status_in,
  input  logic [7:0]                      irq_in,
  output logic [32*C_NUM_USER-1:0]        user_regs,
  output logic                            host_interrupt
);
  localparam logic [9:0] NUM_REGS = 10'(REG_USER_BASE + C_NUM_USER);
  logic        aw_held, w_held, aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok, en_we;
  logic [9:0]  aw_idx, wr_idx, rd_idx;
  logic [31:0] w_data, wr_data, rd_data, rd_user;
  logic [3:0]  w_strb, wr_strb;
  logic [7:0]  clr, pend, en;
  logic [31:0] user_q [C_NUM_USER];
  logic        unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWADDR, S_AXI_ARADDR};
  // readies are forced low while reset is asserted
  assign S_AXI_AWREADY = S_AXI_ARESETN & ~aw_held;
  assign S_AXI_WREADY  = S_AXI_ARESETN & ~w_held;
  assign S_AXI_ARREADY = S_AXI_ARESETN & ~S_AXI_RVALID;
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  // a beat handshaking this cycle is used directly so the commit needs no extra cycle
  assign wr_idx  = aw_held ? aw_idx : S_AXI_AWADDR[11:2];
  assign wr_data = w_held ? w_data : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;
  assign commit  = (aw_held | aw_hs) & (w_held | w_hs) & (~S_AXI_BVALID | S_AXI_BREADY);
  assign wr_ok   = wr_idx < NUM_REGS;
  assign en_we   = commit & (wr_idx == REG_IRQ_EN) & wr_strb[0];
  assign clr     = (commit & (wr_idx == REG_IRQ_PEND) & wr_strb[0]) ? wr_data[7:0] : 8'h00;
  assign rd_idx  = S_AXI_ARADDR[11:2];
  assign rd_ok   = rd_idx < NUM_REGS;
  always_comb begin
    rd_user = '0;
    for (int i = 0; i < C_NUM_USER; i++) rd_user = (rd_idx == 10'(REG_USER_BASE + i)) ? user_q[i] : rd_user;
    rd_data = rd_idx == REG_CTRL     ? ctrl_out :
              rd_idx == REG_STATUS   ? status_in :
              rd_idx == REG_IRQ_PEND ? {24'h0, pend} :
              rd_idx == REG_IRQ_EN   ? {24'h0, en} : rd_user;
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      aw_held      <= 1'b0;
      aw_idx       <= '0;
      w_held       <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
      ctrl_out     <= '0;
    end else begin
      aw_held      <= ~commit & (aw_held | aw_hs);
      aw_idx       <= aw_hs ? S_AXI_AWADDR[11:2] : aw_idx;
      w_held       <= ~commit & (w_held | w_hs);
      w_data       <= w_hs ? S_AXI_WDATA : w_data;
      w_strb       <= w_hs ? S_AXI_WSTRB : w_strb;
      S_AXI_BVALID <= commit | (S_AXI_BVALID & ~S_AXI_BREADY);
      S_AXI_BRESP  <= commit ? (wr_ok ? RESP_OKAY : RESP_SLVERR) : S_AXI_BRESP;
      S_AXI_RVALID <= ar_hs | (S_AXI_RVALID & ~S_AXI_RREADY);
      S_AXI_RDATA  <= ar_hs ? rd_data : S_AXI_RDATA;
      S_AXI_RRESP  <= ar_hs ? (rd_ok ? RESP_OKAY : RESP_SLVERR) : S_AXI_RRESP;
      ctrl_out     <= (commit && wr_idx == REG_CTRL) ? strb_merge(ctrl_out, wr_data, wr_strb) : ctrl_out;
    end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < C_NUM_USER; i++) user_q[i] <= '0;
    end else begin
      for (int i = 0; i < C_NUM_USER; i++)
        user_q[i] <= (commit && wr_idx == 10'(REG_USER_BASE + i)) ? strb_merge(user_q[i], wr_data, wr_strb) : user_q[i];
    end
  for (genvar n = 0; n < C_NUM_USER; n++) begin : g_user
    assign user_regs[32*n +: 32] = user_q[n];
  end
  xillybus_irq_ctrl u_irq (
    .clk           (S_AXI_ACLK),
    .rst_n         (S_AXI_ARESETN),
    .irq_in        (irq_in),
    .en_we         (en_we),
    .en_wdata      (wr_data[7:0]),
    .clr           (clr),
    .pend          (pend),
    .en            (en),
    .host_interrupt(host_interrupt)
  );
endmodule

// File: tb/tb_xillybus_lite_regfile.sv
// tb_xillybus_lite_regfile: randomized self-checking bench for xillybus_lite_regfile against a register-map model
module tb_xillybus_lite_regfile;
  localparam int NU = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] S_AXI_AWADDR = '0, S_AXI_WDATA = '0, S_AXI_ARADDR = '0, S_AXI_RDATA, status_in = '0, ctrl_out;
  logic [3:0] S_AXI_WSTRB = '0;
  logic S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0, S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
  logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, host_interrupt;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic [7:0] irq_in = '0;
  logic [32*NU-1:0] user_regs;
  int tests = 0, fails = 0;
  logic [31:0] m_ctrl, m_user [NU];
  logic [7:0] m_pend, m_en;

  xillybus_lite_regfile #(.C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .C_NUM_USER(NU)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ctrl_out(ctrl_out), .status_in(status_in), .irq_in(irq_in), .user_regs(user_regs), .host_interrupt(host_interrupt)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [32*NU-1:0] packed_users();
    logic [32*NU-1:0] r;
    for (int i = 0; i < NU; i++) r[32*i +: 32] = m_user[i];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0: return m_ctrl;
      1: return status_in;
      2: return {24'h0, m_pend};
      3: return {24'h0, m_en};
      default: return (idx >= 4 && idx < 4 + NU) ? m_user[idx-4] : 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_pend = '0; m_en = '0;
    for (int i = 0; i < NU; i++) m_user[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, output logic [1:0] resp);
    int n;
    logic aw_go, w_go;
    n = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
    while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 50) begin
      aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
      w_go = S_AXI_WVALID && S_AXI_WREADY;
      tick(); n++;
      if (aw_go) S_AXI_AWVALID = 0;
      if (w_go) S_AXI_WVALID = 0;
    end
    while (!S_AXI_BVALID && n < 50) begin tick(); n++; end
    tests++;
    if (n >= 50) begin
      fails++;
      $display("FAIL write_timeout addr=%h: BVALID=%b after 50 cycles, required 1", addr, S_AXI_BVALID);
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    end
    resp = S_AXI_BRESP;
    tick();
    S_AXI_BREADY = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic go;
    n = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
    while (S_AXI_ARVALID && n < 50) begin
      go = S_AXI_ARREADY;
      tick(); n++;
      if (go) S_AXI_ARVALID = 0;
    end
    while (!S_AXI_RVALID && n < 50) begin tick(); n++; end
    tests++;
    if (n >= 50) begin
      fails++;
      $display("FAIL read_timeout addr=%h: RVALID=%b after 50 cycles, required 1", addr, S_AXI_RVALID);
      S_AXI_ARVALID = 0;
    end
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    tick();
    S_AXI_RREADY = 0;
  endtask

  task automatic reg_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    logic [1:0] resp, exp;
    idx = int'(addr[11:2]);
    exp = idx < 4 + NU ? 2'b00 : 2'b10;
    axi_write(addr, data, strb, resp);
    tests++;
    if (resp !== exp) begin fails++; $display("FAIL write_bresp addr=%h: got %b, required %b", addr, resp, exp); end
    if (idx == 0) m_ctrl = merge(m_ctrl, data, strb);
    if (idx == 2 && strb[0]) m_pend = m_pend & ~data[7:0];
    if (idx == 3 && strb[0]) m_en = data[7:0];
    if (idx >= 4 && idx < 4 + NU) m_user[idx-4] = merge(m_user[idx-4], data, strb);
  endtask

  task automatic reg_read(input logic [31:0] addr);
    int idx;
    logic [31:0] d, exp_d;
    logic [1:0] r, exp_r;
    idx = int'(addr[11:2]);
    exp_d = model_read(idx);
    exp_r = idx < 4 + NU ? 2'b00 : 2'b10;
    axi_read(addr, d, r);
    tests += 2;
    if (d !== exp_d) begin fails++; $display("FAIL read_data addr=%h: got %h, required %h", addr, d, exp_d); end
    if (r !== exp_r) begin fails++; $display("FAIL read_resp addr=%h: got %b, required %b", addr, r, exp_r); end
  endtask

  task automatic check_reset_values(input string name);
    tests += 4;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b11100) begin
      fails++; $display("FAIL %s_handshake: got %b, required 11100", name, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
    if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA} !== 36'h0) begin
      fails++; $display("FAIL %s_resp_data: bresp=%b rresp=%b rdata=%h, required all zero", name, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA);
    end
    if ({ctrl_out, user_regs} !== '0) begin
      fails++; $display("FAIL %s_regs: ctrl=%h users=%h, required zero", name, ctrl_out, user_regs);
    end
    if (host_interrupt !== 1'b0) begin fails++; $display("FAIL %s_irq: got %b, required 0", name, host_interrupt); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (3) tick();
    tests++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
      fails++; $display("FAIL in_reset_handshake: got %b, required 00000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
    rst_n = 1;
    tick();
    check_reset_values("reset");
  endtask

  task automatic test_user_timing();
    S_AXI_BREADY = 0;
    S_AXI_AWADDR = 32'h10; S_AXI_AWVALID = 1;
    tick();
    S_AXI_AWVALID = 0;
    tick(); tick();
    tests += 2;
    if (S_AXI_BVALID !== 1'b0) begin fails++; $display("FAIL aw_only_bvalid: got %b, required 0", S_AXI_BVALID); end
    if (user_regs[31:0] !== 32'h0) begin fails++; $display("FAIL aw_only_user0: got %h, required 0", user_regs[31:0]); end
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    tick();
    S_AXI_WVALID = 0;
    tests += 3;
    if (S_AXI_BVALID !== 1'b1) begin fails++; $display("FAIL late_w_bvalid: got %b, required 1", S_AXI_BVALID); end
    if (S_AXI_BRESP !== 2'b00) begin fails++; $display("FAIL late_w_bresp: got %b, required 00", S_AXI_BRESP); end
    if (user_regs[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL late_w_user0: got %h, required deadbeef", user_regs[31:0]); end
    m_user[0] = 32'hDEADBEEF;
    S_AXI_BREADY = 1;
    tick();
    S_AXI_BREADY = 0;
    tests++;
    if (S_AXI_BVALID !== 1'b0) begin fails++; $display("FAIL b_drain: got %b, required 0", S_AXI_BVALID); end
    reg_read(32'h10);
  endtask

  task automatic test_strobe();
    reg_write(32'h0, 32'h12345678, 4'hF);
    reg_write(32'h0, 32'h000000AA, 4'h1);
    tests++;
    if (ctrl_out !== 32'h123456AA) begin fails++; $display("FAIL strobe_ctrl: got %h, required 123456aa", ctrl_out); end
    reg_read(32'h0);
  endtask

  task automatic test_out_of_range();
    reg_write(32'h400, 32'hFFFFFFFF, 4'hF);
    reg_read(32'h400);
    tests++;
    if (ctrl_out !== 32'h123456AA || user_regs !== packed_users()) begin
      fails++; $display("FAIL oor_no_change: ctrl=%h users=%h, required ctrl=123456aa users=%h", ctrl_out, user_regs, packed_users());
    end
  endtask

  task automatic test_back_to_back();
    int naw, nw;
    S_AXI_BREADY = 0;
    S_AXI_AWADDR = 32'h14; S_AXI_WDATA = 32'hA1A1A1A1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    m_user[1] = 32'hA1A1A1A1;
    tests++;
    if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b100 || user_regs[63:32] !== 32'hA1A1A1A1) begin
      fails++; $display("FAIL b2b_first: bvalid=%b bresp=%b user1=%h, required 1/00/a1a1a1a1", S_AXI_BVALID, S_AXI_BRESP, user_regs[63:32]);
    end
    repeat (4) tick();
    S_AXI_AWADDR = 32'h400; S_AXI_WDATA = 32'h55555555;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    naw = 0; nw = 0;
    repeat (3) begin
      naw += int'(S_AXI_AWVALID && S_AXI_AWREADY);
      nw += int'(S_AXI_WVALID && S_AXI_WREADY);
      tick();
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    tests += 3;
    if (naw != 1 || nw != 1) begin fails++; $display("FAIL b2b_accept_count: aw=%0d w=%0d, required 1 and 1", naw, nw); end
    if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b00) begin fails++; $display("FAIL b2b_stall_ready: got %b, required 00", {S_AXI_AWREADY, S_AXI_WREADY}); end
    if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b100) begin fails++; $display("FAIL b2b_stall_b: got %b, required 100", {S_AXI_BVALID, S_AXI_BRESP}); end
    S_AXI_BREADY = 1;
    tick();
    tests += 2;
    if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b110) begin fails++; $display("FAIL b2b_second_b: got %b, required 110", {S_AXI_BVALID, S_AXI_BRESP}); end
    if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11) begin fails++; $display("FAIL b2b_ready_back: got %b, required 11", {S_AXI_AWREADY, S_AXI_WREADY}); end
    tick();
    S_AXI_BREADY = 0;
    tests += 2;
    if (S_AXI_BVALID !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %b, required 0", S_AXI_BVALID); end
    if (user_regs !== packed_users()) begin fails++; $display("FAIL b2b_users: got %h, required %h", user_regs, packed_users()); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] old_v, new_v;
    old_v = m_user[2];
    new_v = $urandom;
    S_AXI_AWADDR = 32'h18; S_AXI_WDATA = new_v; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 32'h18;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1; S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    m_user[2] = new_v;
    tests += 2;
    if ({S_AXI_RVALID, S_AXI_BVALID} !== 2'b11 || S_AXI_RDATA !== old_v) begin
      fails++; $display("FAIL same_cycle_read: rvalid=%b bvalid=%b rdata=%h, required 1/1/%h", S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA, old_v);
    end
    if (user_regs[95:64] !== new_v) begin fails++; $display("FAIL same_cycle_write: got %h, required %h", user_regs[95:64], new_v); end
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    tick();
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
  endtask

  task automatic test_read_rate();
    int n;
    n = 0;
    S_AXI_ARADDR = 32'h0; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
    repeat (6) begin
      n += int'(S_AXI_ARVALID && S_AXI_ARREADY);
      tick();
    end
    S_AXI_ARVALID = 0;
    if (S_AXI_RVALID) tick();
    S_AXI_RREADY = 0;
    tests++;
    if (n != 3) begin fails++; $display("FAIL read_rate: got %0d reads in 6 cycles, required 3", n); end
  endtask

  task automatic test_random();
    int idx;
    logic [31:0] addr;
    repeat (60) begin
      idx = $urandom_range(0, 9);
      addr = ($urandom & 32'hFFFFF000) | (idx << 2) | $urandom_range(0, 3);
      status_in = $urandom;
      if ($urandom_range(0, 1) == 1) reg_write(addr, $urandom, 4'($urandom_range(0, 15)));
      else reg_read(addr);
    end
    tests++;
    if (ctrl_out !== m_ctrl || user_regs !== packed_users()) begin
      fails++; $display("FAIL random_final: ctrl=%h users=%h, required ctrl=%h users=%h", ctrl_out, user_regs, m_ctrl, packed_users());
    end
  endtask

  task automatic test_irq();
    reg_write(32'h08, 32'hFF, 4'h1);
    reg_write(32'h0C, 32'h01, 4'h1);
    tick(); tick();
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tests++;
    if (host_interrupt !== 1'b0) begin fails++; $display("FAIL irq_t1: got %b, required 0", host_interrupt); end
    tick();
    tests++;
    if (host_interrupt !== 1'b1) begin fails++; $display("FAIL irq_t2: got %b, required 1", host_interrupt); end
    m_pend = m_pend | 8'h01;
    reg_read(32'h08);
    S_AXI_AWADDR = 32'h08; S_AXI_WDATA = 32'h01; S_AXI_WSTRB = 4'h1;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1; irq_in = 8'h01;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    tests++;
    if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b100) begin fails++; $display("FAIL irq_w1c_b: got %b, required 100", {S_AXI_BVALID, S_AXI_BRESP}); end
    tick();
    S_AXI_BREADY = 0;
    reg_read(32'h08);
    tests++;
    if (host_interrupt !== 1'b1) begin fails++; $display("FAIL irq_set_wins: got %b, required 1", host_interrupt); end
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    m_pend = 8'h00;
    tests++;
    if (host_interrupt !== 1'b1) begin fails++; $display("FAIL irq_clr_t1: got %b, required 1", host_interrupt); end
    tick();
    S_AXI_BREADY = 0;
    tests++;
    if (host_interrupt !== 1'b0) begin fails++; $display("FAIL irq_clr_t2: got %b, required 0", host_interrupt); end
    irq_in = 8'h00;
    tick();
  endtask

  task automatic test_irq_random();
    logic [7:0] prev, nxt;
    logic exp;
    reg_write(32'h0C, 32'hA5, 4'h1);
    prev = irq_in;
    repeat (40) begin
      nxt = 8'($urandom & $urandom & $urandom);
      irq_in = nxt;
      exp = |(m_pend & m_en);
      m_pend = m_pend | (nxt & ~prev);
      prev = nxt;
      tick();
      tests++;
      if (host_interrupt !== exp) begin fails++; $display("FAIL irq_random_host: got %b, required %b (pend=%h)", host_interrupt, exp, m_pend); end
    end
    irq_in = 8'h00;
    tick();
    reg_read(32'h08);
    reg_write(32'h08, 32'hFF, 4'h1);
    tick(); tick();
    tests++;
    if (host_interrupt !== 1'b0) begin fails++; $display("FAIL irq_random_cleared: got %b, required 0", host_interrupt); end
  endtask

  task automatic test_reset_mid();
    reg_write(32'h0C, 32'h01, 4'h1);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick(); tick();
    S_AXI_AWADDR = 32'h10; S_AXI_WDATA = 32'h0BADF00D; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 32'h10;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1; S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    tests++;
    if ({S_AXI_BVALID, S_AXI_RVALID, host_interrupt} !== 3'b111) begin
      fails++; $display("FAIL pre_reset: bvalid/rvalid/irq=%b, required 111", {S_AXI_BVALID, S_AXI_RVALID, host_interrupt});
    end
    #2 rst_n = 0;
    #1;
    tests++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 5'b0) begin
      fails++; $display("FAIL async_reset_drop: got %b, required 00000", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    model_reset();
    tick(); tick();
    rst_n = 1;
    tick();
    check_reset_values("reset_mid");
    reg_read(32'h08);
    reg_read(32'h0C);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_user_timing();
    test_strobe();
    test_out_of_range();
    test_back_to_back();
    test_same_cycle();
    test_read_rate();
    test_random();
    test_irq();
    test_irq_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
